// File: rtl/passageway_plant.sv
// rtl/passageway_plant.sv - cycle-accurate passageway plant: zone walk, door sub-FSM, step budget, sticky fault
module passageway_plant #(
  parameter int NZONES     = 5,
  parameter int DOOR_DELAY = 2,
  parameter int MAX_STEPS  = 255,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iup,
  input  logic              iright,
  input  logic              fault_inject,
  output logic [NZONES-1:0] zone_oh,
  output logic              open,
  output logic              doorstep,
  output logic              fault,
  output logic [CNT_W-1:0]  step_count
);

  localparam int ZW = (NZONES > 1) ? $clog2(NZONES) : 1;
  localparam logic [ZW-1:0]    LAST_ZONE = ZW'(NZONES - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST = CNT_W'(DOOR_DELAY - 1);
  localparam logic [CNT_W-1:0] STEP_MAX  = CNT_W'(MAX_STEPS);

  typedef enum logic [1:0] {S_ROOM, S_OPEN, S_DOORSTEP} sub_t;

  sub_t             sub, sub_nxt;
  logic [ZW-1:0]    zone, zone_nxt;
  logic [CNT_W-1:0] door_cnt, door_cnt_nxt;
  logic [CNT_W-1:0] steps_nxt;
  logic             fault_nxt;
  logic [NZONES-1:0] zone_oh_nxt;

  always_comb begin
    sub_nxt      = sub;
    zone_nxt     = zone;
    door_cnt_nxt = door_cnt;
    steps_nxt    = step_count;
    fault_nxt    = fault;
    if (!fault) begin
      // Fault (injected or budget) wins over any move in the same cycle.
      if (fault_inject || step_count == STEP_MAX) begin
        fault_nxt = 1'b1;
      end else begin
        steps_nxt = step_count + 1'b1;
        case (sub)
          S_ROOM: begin
            if (iup) begin
              door_cnt_nxt = '0;
            end else if (door_cnt == DOOR_LAST) begin
              sub_nxt      = S_OPEN;
              door_cnt_nxt = '0;
            end else begin
              door_cnt_nxt = door_cnt + 1'b1;
            end
          end
          S_OPEN: begin
            if (iup)         sub_nxt = S_ROOM;
            else if (iright) sub_nxt = S_DOORSTEP;
          end
          S_DOORSTEP: begin
            if (!iright) begin
              sub_nxt = S_OPEN;
            end else if (zone != LAST_ZONE) begin
              zone_nxt = zone + 1'b1;
              sub_nxt  = S_OPEN;
            end
          end
          default: sub_nxt = S_ROOM;
        endcase
      end
    end
    for (int i = 0; i < NZONES; i++) begin
      zone_oh_nxt[i] = (zone_nxt == ZW'(i));
    end
  end

  // Outputs are registered from the next-state values so they track the state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub        <= S_ROOM;
      zone       <= '0;
      door_cnt   <= '0;
      step_count <= '0;
      fault      <= 1'b0;
      zone_oh    <= NZONES'(1);
      open       <= 1'b0;
      doorstep   <= 1'b0;
    end else begin
      sub        <= sub_nxt;
      zone       <= zone_nxt;
      door_cnt   <= door_cnt_nxt;
      step_count <= steps_nxt;
      fault      <= fault_nxt;
      zone_oh    <= zone_oh_nxt;
      open       <= (sub_nxt == S_OPEN) || (sub_nxt == S_DOORSTEP);
      doorstep   <= (sub_nxt == S_DOORSTEP);
    end
  end

endmodule

// File: tb/tb_passageway_plant.sv
// tb/tb_passageway_plant.sv - randomized self-checking bench for passageway_plant
module tb_passageway_plant;
  localparam int NZ = 5;
  localparam int DD = 2;
  localparam int MS = 255;
  localparam int CW = 8;
  localparam int OW = NZ + 3 + CW;

  logic clk = 1'b0;
  logic rst_n, iup, iright, fault_inject;
  logic [NZ-1:0] zone_oh;
  logic open, doorstep, fault;
  logic [CW-1:0] step_count;

  logic rst4_n, iup4, iright4, inj4;
  logic [NZ-1:0] zone_oh4;
  logic open4, doorstep4, fault4;
  logic [CW-1:0] step_count4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  passageway_plant #(.NZONES(NZ), .DOOR_DELAY(DD), .MAX_STEPS(MS), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .iup(iup), .iright(iright), .fault_inject(fault_inject),
    .zone_oh(zone_oh), .open(open), .doorstep(doorstep), .fault(fault), .step_count(step_count));

  passageway_plant #(.NZONES(NZ), .DOOR_DELAY(DD), .MAX_STEPS(4), .CNT_W(CW)) dut4 (
    .clk(clk), .rst_n(rst4_n), .iup(iup4), .iright(iright4), .fault_inject(inj4),
    .zone_oh(zone_oh4), .open(open4), .doorstep(doorstep4), .fault(fault4), .step_count(step_count4));

  logic [OW-1:0] obs, obs4;
  assign obs  = {zone_oh, open, doorstep, fault, step_count};
  assign obs4 = {zone_oh4, open4, doorstep4, fault4, step_count4};

  localparam logic [OW-1:0] RESET_OBS = {5'b00001, 1'b0, 1'b0, 1'b0, 8'd0};

  // Reference model: mode 0=room, 1=open strip, 2=doorstep
  int m_zone, m_mode, m_dcnt, m_steps;
  bit m_fault;

  function automatic void model_reset();
    m_zone = 0; m_mode = 0; m_dcnt = 0; m_steps = 0; m_fault = 0;
  endfunction

  function automatic void model_edge(bit up, bit right, bit inj);
    if (m_fault) return;
    if (inj || m_steps == MS) begin
      m_fault = 1;
      return;
    end
    m_steps++;
    if (m_mode == 0) begin
      if (up) m_dcnt = 0;
      else if (m_dcnt == DD - 1) begin m_mode = 1; m_dcnt = 0; end
      else m_dcnt++;
    end else if (m_mode == 1) begin
      if (up) m_mode = 0;
      else if (right) m_mode = 2;
    end else begin
      if (!right) m_mode = 1;
      else if (m_zone < NZ - 1) begin m_zone++; m_mode = 1; end
    end
  endfunction

  function automatic logic [OW-1:0] exp_obs();
    logic [NZ-1:0] oh;
    oh = '0;
    oh[m_zone] = 1'b1;
    return {oh, m_mode != 0, m_mode == 2, m_fault, m_steps[CW-1:0]};
  endfunction

  task automatic cycle(input bit up, input bit right, input bit inj);
    iup = up; iright = right; fault_inject = inj;
    @(posedge clk);
    model_edge(up, right, inj);
    #1;
  endtask

  task automatic do_reset();
    iup = 0; iright = 0; fault_inject = 0;
    rst_n = 0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== RESET_OBS) begin failures++; $display("FAIL reset_state obs=%h exp=%h", obs, RESET_OBS); end
    cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 1, 0);
    #2 rst_n = 0;
    #1;
    checks++;
    if (obs !== RESET_OBS) begin failures++; $display("FAIL async_reset obs=%h exp=%h", obs, RESET_OBS); end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_open();
    do_reset();
    cycle(0, 0, 0);
    checks++;
    if (open !== 1'b0) begin failures++; $display("FAIL open_early open=%b exp=0", open); end
    cycle(0, 0, 0);
    checks++;
    if (obs !== {5'b00001, 1'b1, 1'b0, 1'b0, 8'd2}) begin
      failures++; $display("FAIL open_after_delay obs=%h exp=%h", obs, {5'b00001, 1'b1, 1'b0, 1'b0, 8'd2});
    end
    cycle(0, 1, 0);
    checks++;
    if ({open, doorstep} !== 2'b11) begin failures++; $display("FAIL doorstep_enter got=%b exp=11", {open, doorstep}); end
    cycle(0, 1, 0);
    checks++;
    if ({zone_oh, open, doorstep} !== {5'b00010, 2'b10}) begin
      failures++; $display("FAIL zone_advance got=%b exp=%b", {zone_oh, open, doorstep}, {5'b00010, 2'b10});
    end
  endtask

  task automatic test_full_walk();
    do_reset();
    repeat (4) begin cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 1, 0); cycle(0, 1, 0); end
    checks++;
    if (zone_oh !== 5'b10000) begin failures++; $display("FAIL full_walk zone_oh=%b exp=10000", zone_oh); end
    cycle(0, 1, 0); cycle(0, 1, 0);
    checks++;
    if ({zone_oh, doorstep} !== {5'b10000, 1'b1}) begin
      failures++; $display("FAIL last_zone_hold got=%b exp=%b", {zone_oh, doorstep}, {5'b10000, 1'b1});
    end
    checks++;
    if (obs !== exp_obs()) begin failures++; $display("FAIL full_walk_model obs=%h exp=%h", obs, exp_obs()); end
  endtask

  task automatic test_room_alternate();
    bit rose;
    do_reset();
    rose = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(i % 2 == 1, 0, 0);
      if (open) rose = 1;
    end
    checks++;
    if (rose !== 1'b0) begin failures++; $display("FAIL room_alternate open_rose=%b exp=0", rose); end
    cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 1, 0);
    cycle(1, 0, 0);
    checks++;
    if ({zone_oh, open, doorstep} !== {5'b00001, 2'b10}) begin
      failures++; $display("FAIL doorstep_back got=%b exp=%b", {zone_oh, open, doorstep}, {5'b00001, 2'b10});
    end
  endtask

  task automatic test_fault_inject();
    logic [OW-1:0] frozen;
    bit moved;
    do_reset();
    repeat (2) begin cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 1, 0); cycle(0, 1, 0); end
    cycle(0, 1, 0);
    cycle(0, 1, 1);
    checks++;
    if ({zone_oh, fault, doorstep} !== {5'b00100, 2'b11}) begin
      failures++; $display("FAIL fault_inject got=%b exp=%b", {zone_oh, fault, doorstep}, {5'b00100, 2'b11});
    end
    checks++;
    if (obs !== exp_obs()) begin failures++; $display("FAIL fault_inject_model obs=%h exp=%h", obs, exp_obs()); end
    frozen = obs;
    moved = 0;
    for (int i = 0; i < 10; i++) begin
      cycle($urandom_range(1), $urandom_range(1), $urandom_range(1));
      if (obs !== frozen) moved = 1;
    end
    checks++;
    if (moved !== 1'b0) begin failures++; $display("FAIL fault_frozen obs=%h exp=%h", obs, frozen); end
  endtask

  task automatic test_random();
    int bad;
    for (int run = 0; run < 3; run++) begin
      do_reset();
      bad = 0;
      for (int i = 0; i < 300; i++) begin
        cycle($urandom_range(3) == 0, $urandom_range(1), (run == 1) && ($urandom_range(99) == 0));
        if (obs !== exp_obs()) begin
          bad++;
          if (bad < 4) $display("FAIL random run=%0d cyc=%0d obs=%h exp=%h", run, i, obs, exp_obs());
        end
      end
      checks++;
      if (bad != 0) failures++;
    end
    checks++;
    if (!(fault === 1'b1 && step_count === 8'd255)) begin
      failures++; $display("FAIL budget_255 fault=%b steps=%0d exp fault=1 steps=255", fault, step_count);
    end
  endtask

  task automatic test_budget();
    iup4 = 0; iright4 = 0; inj4 = 0;
    rst4_n = 0;
    @(posedge clk); #1;
    rst4_n = 1;
    for (int i = 0; i < 4; i++) begin
      iup4 = 1'($urandom_range(1)); iright4 = 1'($urandom_range(1));
      @(posedge clk); #1;
    end
    checks++;
    if ({fault4, step_count4} !== {1'b0, 8'd4}) begin
      failures++; $display("FAIL budget_4_edges fault=%b steps=%0d exp fault=0 steps=4", fault4, step_count4);
    end
    @(posedge clk); #1;
    checks++;
    if ({fault4, step_count4} !== {1'b1, 8'd4}) begin
      failures++; $display("FAIL budget_5_edges fault=%b steps=%0d exp fault=1 steps=4", fault4, step_count4);
    end
    #3 rst4_n = 0;
    #1;
    checks++;
    if (obs4 !== RESET_OBS) begin failures++; $display("FAIL budget_async_reset obs=%h exp=%h", obs4, RESET_OBS); end
    @(posedge clk); #1;
    rst4_n = 1;
  endtask

  initial begin
    rst_n = 0; iup = 0; iright = 0; fault_inject = 0;
    rst4_n = 0; iup4 = 0; iright4 = 0; inj4 = 0;
    #2;
    test_reset();
    test_open();
    test_full_walk();
    test_room_alternate();
    test_fault_inject();
    test_random();
    test_budget();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
